// File: rtl/mux_select_sequencer.sv
// Serializes a 4-bit word through a 4:1 mux by stepping its select, one bit per HOLD_CYCLES clocks.
// Optional feature: define MUX_SEQ_BACKPRESSURE_EN to add the out_ready stall input.
`timescale 1ns/1ps
module mux_select_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] word_q,
  output logic [1:0] sel,
  output logic       bit_valid,
  output logic       last_bit,
  output logic       done
`ifdef MUX_SEQ_BACKPRESSURE_EN
  , input  logic     out_ready
`endif
);

  localparam int            CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    bit_idx;
  logic          advance;

`ifdef MUX_SEQ_BACKPRESSURE_EN
  assign advance = out_ready;
`else
  assign advance = 1'b1;
`endif

  // All outputs are registered; in_ready leaves reset high so IDLE accepts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_q    <= 4'd0;
      sel       <= FIRST_SEL;
      hold_cnt  <= '0;
      bit_idx   <= 2'd0;
      bit_valid <= 1'b0;
      last_bit  <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            word_q    <= in_data;
            sel       <= FIRST_SEL;
            bit_idx   <= 2'd0;
            hold_cnt  <= '0;
            bit_valid <= 1'b1;
            last_bit  <= 1'b0;
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (advance) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (bit_idx == 2'd3) begin
                bit_valid <= 1'b0;
                last_bit  <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                bit_idx  <= bit_idx + 2'd1;
                sel      <= MSB_FIRST ? sel - 2'd1 : sel + 2'd1;
                // last_bit tracks the bit_idx value being entered
                last_bit <= (bit_idx == 2'd2);
              end
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: two instances (HOLD=1 LSB-first, HOLD=3 MSB-first) against a per-cycle stream model.
`timescale 1ns/1ps
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       which = 1'b0;
`ifdef MUX_SEQ_BACKPRESSURE_EN
  logic       out_ready = 1'b1;
`endif

  logic       rdy1, bv1, last1, done1, rdy3, bv3, last3, done3;
  logic [3:0] word1, word3;
  logic [1:0] sel1, sel3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_select_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !which), .in_data(in_data),
    .in_ready(rdy1), .word_q(word1), .sel(sel1), .bit_valid(bv1),
    .last_bit(last1), .done(done1)
`ifdef MUX_SEQ_BACKPRESSURE_EN
    , .out_ready(out_ready)
`endif
  );

  mux_select_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && which), .in_data(in_data),
    .in_ready(rdy3), .word_q(word3), .sel(sel3), .bit_valid(bv3),
    .last_bit(last3), .done(done3)
`ifdef MUX_SEQ_BACKPRESSURE_EN
    , .out_ready(out_ready)
`endif
  );

  // Observed view of whichever instance is under test
  logic       o_rdy, o_bv, o_last, o_done;
  logic [3:0] o_word;
  logic [1:0] o_sel;
  assign o_rdy  = which ? rdy3  : rdy1;
  assign o_bv   = which ? bv3   : bv1;
  assign o_last = which ? last3 : last1;
  assign o_done = which ? done3 : done1;
  assign o_word = which ? word3 : word1;
  assign o_sel  = which ? sel3  : sel1;

  // Model: after accept, the stream is bit index order (0..3 or 3..0), each repeated
  // hold times per advancing cycle, then one done cycle, then one idle cycle.
  task automatic run_word(input logic [3:0] w, input int hold, input bit msb,
                          input bit keep_valid, input int stall_mode, input int abort_at,
                          input string name, output int acc_cyc);
    int p, idx, stalls, bv_cnt, n, last_idx;
    logic [1:0] first_sel;
    p = 0; stalls = 0; bv_cnt = 0;
    last_idx  = msb ? 0 : 3;
    first_sel = msb ? 2'd3 : 2'd0;
    in_valid = 1'b1;
    in_data  = w;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: in_ready=%b expected 1", name, o_rdy);
    end
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    for (n = 0; n < 200; n++) begin
      if (p < 4 * hold) begin
        idx = msb ? 3 - p / hold : p / hold;
        bv_cnt++;
        checks++;
        if (o_bv !== 1'b1 || o_sel !== idx[1:0] || o_word !== w || o_word[o_sel] !== w[idx] ||
            o_last !== (p / hold == 3) || o_done !== 1'b0 || o_rdy !== 1'b0) begin
          errors++;
          $display("FAIL %s shift p=%0d: sel=%0d bv=%b last=%b done=%b rdy=%b word=%h, expected sel=%0d bv=1 last=%b done=0 rdy=0 word=%h",
                   name, p, o_sel, o_bv, o_last, o_done, o_rdy, o_word, idx, (p / hold == 3), w);
        end
      end else if (p == 4 * hold) begin
        checks++;
        if (o_bv !== 1'b0 || o_done !== 1'b1 || o_last !== 1'b0 || o_rdy !== 1'b0 ||
            o_sel !== last_idx[1:0] || o_word !== w) begin
          errors++;
          $display("FAIL %s done_cycle: bv=%b done=%b last=%b rdy=%b sel=%0d word=%h, expected bv=0 done=1 last=0 rdy=0 sel=%0d word=%h",
                   name, o_bv, o_done, o_last, o_rdy, o_sel, o_word, last_idx, w);
        end
      end else begin
        checks++;
        if (o_bv !== 1'b0 || o_done !== 1'b0 || o_rdy !== 1'b1 || o_sel !== last_idx[1:0] || o_word !== w) begin
          errors++;
          $display("FAIL %s idle_cycle: bv=%b done=%b rdy=%b sel=%0d word=%h, expected bv=0 done=0 rdy=1 sel=%0d word=%h",
                   name, o_bv, o_done, o_rdy, o_sel, o_word, last_idx, w);
        end
        break;
      end
      if (abort_at >= 0 && p == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if (o_bv !== 1'b0 || o_done !== 1'b0 || o_last !== 1'b0 || o_word !== 4'd0 || o_sel !== first_sel) begin
          errors++;
          $display("FAIL %s async_reset: bv=%b done=%b last=%b word=%h sel=%0d, expected all 0 with sel=%0d",
                   name, o_bv, o_done, o_last, o_word, o_sel, first_sel);
        end
        $display("word %s data=%h aborted at p=%0d", name, w, p);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (keep_valid) in_data = 4'($urandom);
`ifdef MUX_SEQ_BACKPRESSURE_EN
      if (stall_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
      else if (stall_mode == 2) out_ready = !(p == hold && stalls < 5);
      else                      out_ready = 1'b1;
      if (p < 4 * hold && !out_ready) stalls++;
      else p++;
`else
      p++;
`endif
      @(negedge clk);
    end
    checks++;
    if (n >= 200 || bv_cnt != 4 * hold + stalls) begin
      errors++;
      $display("FAIL %s bit_count: bit_valid cycles=%0d loop=%0d, expected %0d within bound",
               name, bv_cnt, n, 4 * hold + stalls);
    end
    $display("word %s data=%h hold=%0d msb=%0d mode=%0d stalls=%0d bit_valid_cycles=%0d",
             name, w, hold, msb, stall_mode, stalls, bv_cnt);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bv1 !== 1'b0 || done1 !== 1'b0 || last1 !== 1'b0 || word1 !== 4'd0 || sel1 !== 2'd0 ||
        bv3 !== 1'b0 || done3 !== 1'b0 || last3 !== 1'b0 || word3 !== 4'd0 || sel3 !== 2'd3) begin
      errors++;
      $display("FAIL reset_values: bv=%b/%b done=%b/%b last=%b/%b word=%h/%h sel=%0d/%0d, expected zeros with sel=0/3",
               bv1, bv3, done1, done3, last1, last3, word1, word3, sel1, sel3);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1 || bv1 !== 1'b0 || bv3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b/%b bit_valid=%b/%b, expected 1/1 0/0", rdy1, rdy3, bv1, bv3);
    end
    $display("reset checked");
  endtask

  task automatic test_lsb_hold1();
    int a;
    which = 1'b0;
    run_word(4'b1010, 1, 1'b0, 1'b0, 0, -1, "lsb_1010", a);
    for (int i = 0; i < 4; i++) run_word(4'($urandom), 1, 1'b0, 1'b0, 0, -1, "lsb_rand", a);
  endtask

  task automatic test_msb_hold3();
    int a;
    which = 1'b1;
    run_word(4'b1100, 3, 1'b1, 1'b0, 0, -1, "msb_1100", a);
    for (int i = 0; i < 3; i++) run_word(4'($urandom), 3, 1'b1, 1'b0, 0, -1, "msb_rand", a);
    which = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a, prev;
    which = 1'b0;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      run_word(4'($urandom), 1, 1'b0, 1'b1, 0, -1, "b2b", a);
      if (prev >= 0) begin
        checks++;
        if (a - prev != 6) begin
          errors++;
          $display("FAIL b2b_period: accept gap=%0d, expected 6", a - prev);
        end
      end
      prev = a;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int a;
    which = 1'b0;
    run_word(4'hF, 1, 1'b0, 1'b0, 0, 1, "abort_F", a);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done1 !== 1'b0 || bv1 !== 1'b0 || rdy1 !== 1'b1 || sel1 !== 2'd0) begin
        errors++;
        $display("FAIL abort_quiet: done=%b bv=%b rdy=%b sel=%0d, expected 0 0 1 0", done1, bv1, rdy1, sel1);
      end
      @(negedge clk);
    end
    run_word(4'h3, 1, 1'b0, 1'b0, 0, -1, "after_abort_3", a);
    which = 1'b1;
    run_word(4'($urandom), 3, 1'b1, 1'b0, 0, 4, "abort_msb", a);
    run_word(4'h9, 3, 1'b1, 1'b0, 0, -1, "after_abort_msb", a);
    which = 1'b0;
  endtask

`ifdef MUX_SEQ_BACKPRESSURE_EN
  task automatic test_backpressure();
    int a;
    which = 1'b0;
    run_word(4'($urandom), 1, 1'b0, 1'b0, 2, -1, "stall5_sel1", a);
    for (int i = 0; i < 3; i++) run_word(4'($urandom), 1, 1'b0, 1'b0, 1, -1, "stall_rand", a);
    which = 1'b1;
    for (int i = 0; i < 2; i++) run_word(4'($urandom), 3, 1'b1, 1'b0, 1, -1, "stall_rand_msb", a);
    which = 1'b0;
    out_ready = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_hold1();
    test_msb_hold3();
    test_back_to_back();
    test_abort();
`ifdef MUX_SEQ_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
